// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the fetch/memory-stage bus arbiter.
// Holds bus width, FSM state encoding, size codes and the bus command payload.
package mem_bus_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_INST_BUSY    = 3'd1,
    ST_DATA_BUSY    = 3'd2,
    ST_INST_DISCARD = 3'd3,
    ST_RESP         = 3'd4
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [2:0]      size;
    logic [XLEN-1:0] wdata;
  } bus_cmd_t;

  // Unsigned loads share the low two size bits with their signed forms.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic half_bad;
    logic word_bad;
    half_bad = (funct3[1:0] == SIZE_HALF[1:0]) && addr_lo[0];
    word_bad = (funct3[1:0] == SIZE_WORD[1:0]) && (addr_lo != 2'b00);
    return half_bad || word_bad;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between fetch and memory-stage requests,
// plus the next value of the data-grant streak counter.
module mem_arb_select #(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned SW         = 3
) (
  input  logic          i_inst_req,
  input  logic          i_data_req,
  input  logic [SW-1:0] i_streak,
  output logic          o_grant_inst_c,
  output logic          o_grant_data_c,
  output logic [SW-1:0] o_streak_c
);

  logic inst_win;
  logic data_win;

  // Data wins unless fetch has waited through MAX_STREAK data grants.
  always_comb begin
    inst_win = i_inst_req && (!i_data_req || (i_streak == SW'(MAX_STREAK)));
    data_win = i_data_req && !inst_win;

    o_grant_inst_c = inst_win;
    o_grant_data_c = data_win;
    o_streak_c     = i_streak;
    if (inst_win) begin
      o_streak_c = '0;
    end else if (data_win) begin
      o_streak_c = i_inst_req ? (i_streak + SW'(1)) : '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding external memory bus arbiter for fetch and memory stages,
// with misalignment rejection, per-transaction timeout and fetch-flush discard.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_req,
  input  logic [XLEN-1:0] i_inst_addr,
  input  logic            i_inst_flush,
  output logic            o_inst_ack,
  output logic [XLEN-1:0] o_inst_data,
  output logic            o_inst_err,
  input  logic            i_data_req,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic            i_data_we,
  input  logic [2:0]      i_data_funct3,
  input  logic [XLEN-1:0] i_data_wdata,
  output logic            o_data_ack,
  output logic [XLEN-1:0] o_data_rdata,
  output logic            o_data_err,
  output logic            o_bus_req,
  output logic [XLEN-1:0] o_bus_addr,
  output logic            o_bus_we,
  output logic [2:0]      o_bus_size,
  output logic [XLEN-1:0] o_bus_wdata,
  input  logic            i_bus_ack,
  input  logic [XLEN-1:0] i_bus_rdata
);

  localparam int unsigned SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e          state_q, state_d;
  bus_cmd_t        bus_q, bus_d;
  logic            bus_req_q, bus_req_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            inst_ack_q, inst_ack_d;
  logic            inst_err_q, inst_err_d;
  logic [XLEN-1:0] inst_data_q, inst_data_d;
  logic            data_ack_q, data_ack_d;
  logic            data_err_q, data_err_d;
  logic [XLEN-1:0] data_rdata_q, data_rdata_d;

  logic            grant_inst_c;
  logic            grant_data_c;
  logic [SW-1:0]   streak_sel_c;
  logic            timeout_c;

  mem_arb_select #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_select (
    .i_inst_req     (i_inst_req),
    .i_data_req     (i_data_req),
    .i_streak       (streak_q),
    .o_grant_inst_c (grant_inst_c),
    .o_grant_data_c (grant_data_c),
    .o_streak_c     (streak_sel_c)
  );

  // Next-state and registered-output logic; ack/err default low so they pulse.
  always_comb begin
    state_d      = state_q;
    bus_d        = bus_q;
    bus_req_d    = bus_req_q;
    streak_d     = streak_q;
    to_cnt_d     = to_cnt_q;
    inst_ack_d   = 1'b0;
    inst_err_d   = 1'b0;
    inst_data_d  = inst_data_q;
    data_ack_d   = 1'b0;
    data_err_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    timeout_c    = (TIMEOUT != 0) && (to_cnt_q == TW'(TIMEOUT - 1));

    unique case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (grant_inst_c) begin
          streak_d  = streak_sel_c;
          bus_d     = '{addr: i_inst_addr, we: 1'b0, size: SIZE_WORD, wdata: '0};
          bus_req_d = 1'b1;
          state_d   = ST_INST_BUSY;
        end else if (grant_data_c) begin
          streak_d = streak_sel_c;
          if (is_misaligned(i_data_funct3, i_data_addr[1:0])) begin
            data_ack_d   = 1'b1;
            data_err_d   = 1'b1;
            data_rdata_d = '0;
            state_d      = ST_RESP;
          end else begin
            bus_d     = '{addr: i_data_addr, we: i_data_we, size: i_data_funct3,
                          wdata: i_data_wdata};
            bus_req_d = 1'b1;
            state_d   = ST_DATA_BUSY;
          end
        end
      end

      ST_INST_BUSY: begin
        if (i_bus_ack) begin
          bus_req_d = 1'b0;
          if (i_inst_flush) begin
            state_d = ST_IDLE;
          end else begin
            inst_ack_d  = 1'b1;
            inst_data_d = i_bus_rdata;
            state_d     = ST_RESP;
          end
        end else if (timeout_c) begin
          bus_req_d = 1'b0;
          if (i_inst_flush) begin
            state_d = ST_IDLE;
          end else begin
            inst_ack_d  = 1'b1;
            inst_err_d  = 1'b1;
            inst_data_d = '0;
            state_d     = ST_RESP;
          end
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
          if (i_inst_flush) begin
            state_d = ST_INST_DISCARD;
          end
        end
      end

      ST_DATA_BUSY: begin
        if (i_bus_ack) begin
          bus_req_d    = 1'b0;
          data_ack_d   = 1'b1;
          data_rdata_d = i_bus_rdata;
          state_d      = ST_RESP;
        end else if (timeout_c) begin
          bus_req_d    = 1'b0;
          data_ack_d   = 1'b1;
          data_err_d   = 1'b1;
          data_rdata_d = '0;
          state_d      = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      // Bus cycle still owed to the slave; finish it without telling fetch.
      ST_INST_DISCARD: begin
        if (i_bus_ack || timeout_c) begin
          bus_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      bus_q        <= '0;
      bus_req_q    <= 1'b0;
      streak_q     <= '0;
      to_cnt_q     <= '0;
      inst_ack_q   <= 1'b0;
      inst_err_q   <= 1'b0;
      inst_data_q  <= '0;
      data_ack_q   <= 1'b0;
      data_err_q   <= 1'b0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      bus_q        <= bus_d;
      bus_req_q    <= bus_req_d;
      streak_q     <= streak_d;
      to_cnt_q     <= to_cnt_d;
      inst_ack_q   <= inst_ack_d;
      inst_err_q   <= inst_err_d;
      inst_data_q  <= inst_data_d;
      data_ack_q   <= data_ack_d;
      data_err_q   <= data_err_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign o_inst_ack   = inst_ack_q;
  assign o_inst_err   = inst_err_q;
  assign o_inst_data  = inst_data_q;
  assign o_data_ack   = data_ack_q;
  assign o_data_err   = data_err_q;
  assign o_data_rdata = data_rdata_q;
  assign o_bus_req    = bus_req_q;
  assign o_bus_addr   = bus_q.addr;
  assign o_bus_we     = bus_q.we;
  assign o_bus_size   = bus_q.size;
  assign o_bus_wdata  = bus_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table of single transactions,
// scoreboard of expected completions, and hand-written multi-cycle sequences.
module tb_mem_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_inst_req = 1'b0;
  logic [31:0] i_inst_addr = '0;
  logic        i_inst_flush = 1'b0;
  logic        o_inst_ack;
  logic [31:0] o_inst_data;
  logic        o_inst_err;
  logic        i_data_req = 1'b0;
  logic [31:0] i_data_addr = '0;
  logic        i_data_we = 1'b0;
  logic [2:0]  i_data_funct3 = '0;
  logic [31:0] i_data_wdata = '0;
  logic        o_data_ack;
  logic [31:0] o_data_rdata;
  logic        o_data_err;
  logic        o_bus_req;
  logic [31:0] o_bus_addr;
  logic        o_bus_we;
  logic [2:0]  o_bus_size;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  always #5 i_clk = ~i_clk;

  mem_bus_arbiter #(.TIMEOUT(8), .MAX_STREAK(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr), .i_inst_flush(i_inst_flush),
    .o_inst_ack(o_inst_ack), .o_inst_data(o_inst_data), .o_inst_err(o_inst_err),
    .i_data_req(i_data_req), .i_data_addr(i_data_addr), .i_data_we(i_data_we),
    .i_data_funct3(i_data_funct3), .i_data_wdata(i_data_wdata),
    .o_data_ack(o_data_ack), .o_data_rdata(o_data_rdata), .o_data_err(o_data_err),
    .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr), .o_bus_we(o_bus_we),
    .o_bus_size(o_bus_size), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          is_inst;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          is_inst;
    logic [31:0] addr;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] wdata;
    int          delay;
    bit          hang;
    logic [31:0] rdata;
    int          exp_lat;
    bit          exp_err;
    bit          exp_bus;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus slave: acks in the (delay+1)th cycle of o_bus_req unless hung or forced.
  int          bus_delay = 0;
  bit          bus_hang  = 1'b0;
  bit          bus_force = 1'b0;
  logic [31:0] bus_rd    = '0;
  int          req_cnt   = 0;

  always @(negedge i_clk) begin
    if (bus_force) begin
      i_bus_ack   = 1'b1;
      i_bus_rdata = 32'hBAD0BAD0;
      req_cnt     = 0;
    end else if (o_bus_req && !bus_hang) begin
      i_bus_ack   = (req_cnt == bus_delay);
      i_bus_rdata = (req_cnt == bus_delay) ? bus_rd : 32'h0;
      req_cnt++;
    end else begin
      i_bus_ack = 1'b0;
      req_cnt   = 0;
    end
  end

  // Completion monitor: every ack must match the oldest expected entry.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && (o_inst_ack || o_data_ack)) begin
      check("dual_ack", 64'(o_inst_ack & o_data_ack), 64'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {62'd0, o_inst_ack, o_data_ack}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_kind", 64'(o_inst_ack), 64'(e.is_inst));
        check("ack_data", 64'(o_inst_ack ? o_inst_data : o_data_rdata), 64'(e.data));
        check("ack_err", 64'(o_inst_ack ? o_inst_err : o_data_err), 64'(e.err));
      end
    end
  end

  task automatic outputs_zero(input string tag);
    check({tag, "_ctl"}, {54'd0, o_inst_ack, o_inst_err, o_data_ack, o_data_err,
                          o_bus_req, o_bus_we, o_bus_size}, 64'd0);
    check({tag, "_bus"}, {o_bus_addr, o_bus_wdata}, 64'd0);
    check({tag, "_rd"}, {o_inst_data, o_data_rdata}, 64'd0);
  endtask

  // Entered and left just after a negedge; the request is sampled by the next posedge.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit seen_bus;
    bit done;
    bus_delay = v.delay;
    bus_hang  = v.hang;
    bus_rd    = v.rdata;
    if (v.is_inst) begin
      i_inst_req  = 1'b1;
      i_inst_addr = v.addr;
    end else begin
      i_data_req    = 1'b1;
      i_data_addr   = v.addr;
      i_data_we     = v.we;
      i_data_funct3 = v.f3;
      i_data_wdata  = v.wdata;
    end
    sb_q.push_back('{is_inst: v.is_inst, data: (v.exp_err ? 32'h0 : v.rdata), err: v.exp_err});
    lat = 0;
    seen_bus = 1'b0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge i_clk);
      lat++;
      if (o_bus_req && !seen_bus) begin
        seen_bus = 1'b1;
        check({tag, "_addr"}, 64'(o_bus_addr), 64'(v.addr));
        check({tag, "_we_size"}, {60'd0, o_bus_we, o_bus_size},
              {60'd0, (v.is_inst ? 1'b0 : v.we), (v.is_inst ? 3'b010 : v.f3)});
        if (!v.is_inst && v.we) check({tag, "_wdata"}, 64'(o_bus_wdata), 64'(v.wdata));
      end
      if (o_inst_ack || o_data_ack) begin
        done = 1'b1;
        i_inst_req = 1'b0;
        i_data_req = 1'b0;
        check({tag, "_bus_dropped"}, 64'(o_bus_req), 64'd0);
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_bus_issued"}, 64'(seen_bus), 64'(v.exp_bus));
    i_inst_req = 1'b0;
    i_data_req = 1'b0;
    bus_hang   = 1'b0;
    @(negedge i_clk);
  endtask

  vec_t vecs[10];

  initial begin
    string order;
    string exp_order;
    int    ng;
    bit    prev_req;
    vec_t  v_chk;

    vecs[0] = '{1, 32'h100, 0, 3'b010, 32'h0,        2, 0, 32'h00500093, 4, 0, 1};
    vecs[1] = '{0, 32'h1000, 0, 3'b010, 32'h0,       0, 0, 32'hDEADBEEF, 2, 0, 1};
    vecs[2] = '{0, 32'h202, 1, 3'b010, 32'h12345678, 0, 0, 32'h0,        1, 1, 0};
    vecs[3] = '{0, 32'h203, 0, 3'b001, 32'h0,        0, 0, 32'h0,        1, 1, 0};
    vecs[4] = '{0, 32'h202, 0, 3'b001, 32'h0,        1, 0, 32'h0000BEEF, 3, 0, 1};
    vecs[5] = '{0, 32'h203, 0, 3'b000, 32'h0,        0, 0, 32'h000000AB, 2, 0, 1};
    vecs[6] = '{0, 32'h201, 0, 3'b101, 32'h0,        0, 0, 32'h0,        1, 1, 0};
    vecs[7] = '{0, 32'h300, 1, 3'b010, 32'hCAFEF00D, 3, 0, 32'h0,        5, 0, 1};
    vecs[8] = '{0, 32'h400, 0, 3'b010, 32'h0,        0, 1, 32'h0,        9, 1, 1};
    vecs[9] = '{1, 32'h44, 0, 3'b010, 32'h0,         0, 0, 32'h00000013, 2, 0, 1};
    v_chk   = '{0, 32'h800, 0, 3'b010, 32'h0,        0, 0, 32'h5555AAAA, 2, 0, 1};

    repeat (3) @(negedge i_clk);
    outputs_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    outputs_zero("idle");

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Both requesters held: data wins MAX_STREAK times, then fetch gets one grant.
    bus_delay = 0;
    bus_rd    = 32'hA5A50001;
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{is_inst: (i == 4), data: 32'hA5A50001, err: 1'b0});
    end
    i_inst_req = 1'b1;  i_inst_addr = 32'h500;
    i_data_req = 1'b1;  i_data_addr = 32'h600;  i_data_we = 1'b0;  i_data_funct3 = 3'b010;
    order = "";
    exp_order = "DDDDID";
    ng = 0;
    prev_req = 1'b0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      @(negedge i_clk);
      if (o_bus_req && !prev_req) begin
        order = {order, (o_bus_addr == 32'h500) ? "I" : "D"};
        ng++;
        if (ng == 6) i_data_req = 1'b0;
      end
      if (o_inst_ack) i_inst_req = 1'b0;
      prev_req = o_bus_req;
    end
    repeat (4) @(negedge i_clk);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("grant%0d", i), 64'(order.getc(i)), 64'(exp_order.getc(i)));
    end

    // Flush one cycle after o_bus_req; bus still acks later but fetch sees nothing.
    bus_delay = 4;
    bus_rd    = 32'h11111111;
    i_inst_req = 1'b1;  i_inst_addr = 32'h40;
    @(negedge i_clk);
    @(negedge i_clk);
    check("flush_busreq_up", 64'(o_bus_req), 64'd1);
    i_inst_flush = 1'b1;  i_inst_req = 1'b0;
    @(negedge i_clk);
    i_inst_flush = 1'b0;
    @(negedge i_clk);
    check("flush_hold", 64'(o_bus_req), 64'd1);
    @(negedge i_clk);
    @(negedge i_clk);
    check("flush_release", 64'(o_bus_req), 64'd0);
    repeat (3) @(negedge i_clk);
    run_vec(v_chk, "post_flush");

    // Flush on the same cycle as the bus ack: discarded, no completion.
    bus_delay = 1;
    i_inst_req = 1'b1;  i_inst_addr = 32'h80;
    @(negedge i_clk);
    @(negedge i_clk);
    i_inst_flush = 1'b1;  i_inst_req = 1'b0;
    @(negedge i_clk);
    i_inst_flush = 1'b0;
    check("flush_coinc_release", 64'(o_bus_req), 64'd0);
    repeat (3) @(negedge i_clk);
    run_vec(v_chk, "post_coinc");

    // Reset while a load is waiting on the bus; bus acks during and after reset.
    bus_hang = 1'b1;
    i_data_req = 1'b1;  i_data_addr = 32'h900;  i_data_we = 1'b0;  i_data_funct3 = 3'b010;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_mid_busy", 64'(o_bus_req), 64'd1);
    i_rst = 1'b1;  bus_force = 1'b1;  i_data_req = 1'b0;
    @(negedge i_clk);
    outputs_zero("rst_mid");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    bus_force = 1'b0;  bus_hang = 1'b0;
    repeat (4) @(negedge i_clk);
    outputs_zero("rst_after");
    run_vec(v_chk, "post_rst");

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
